adder_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a shared WIDTH-bit ripple-carry adder datapath, of the kind used by the 8-bit counter/adder test designs.
- Each requester presents an operand pair on a valid/ready handshake.
- The block grants one requester at a time, round-robin, and captures its operands.
- It runs the add on the shared ripple-carry adder, registers sum and carry-out, and returns the result on a single tagged response channel.
- It sits between counter-style operand producers and the adder, so nxcompile can be exercised with real arbitration and FSM logic.

---
 rtl/adder_pkg.sv | 15 +
 rtl/ripple_adder.sv | 24 ++
 rtl/adder_arbiter.sv | 122 ++++++++++++
 tb/tb_adder_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the adder arbiter slice.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } adder_arb_state_t;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

endpackage

// File: rtl/ripple_adder.sv
// Combinational ripple-carry adder: half adder at bit 0, full adders above.
module ripple_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry-out.
  logic [WIDTH:1] c;

  assign sum[0] = a[0] ^ b[0];
  assign c[1]   = a[0] & b[0];

  for (genvar i = 1; i < int'(WIDTH); i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing one adder.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid_0,
  input  logic [WIDTH-1:0] i_req_a_0,
  input  logic [WIDTH-1:0] i_req_b_0,
  output logic             o_req_ready_0,
  input  logic             i_req_valid_1,
  input  logic [WIDTH-1:0] i_req_a_1,
  input  logic [WIDTH-1:0] i_req_b_1,
  output logic             o_req_ready_1,
  output logic             o_rsp_valid,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_sum,
  output logic             o_rsp_carry,
  input  logic             i_rsp_ready,
  output logic             o_busy
);

  adder_arb_state_t state_q, state_d;
  req_id_t          rr_q, rr_d;
  req_id_t          id_q;
  req_id_t          grant_id;
  logic             grant_vld;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             rsp_valid_q;
  req_id_t          rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_carry_q;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a_q),
    .b    (b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Arbitration, ready generation and next-state logic.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_vld     = 1'b0;
    grant_id      = 1'b0;
    o_req_ready_0 = 1'b0;
    o_req_ready_1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid_0 && i_req_valid_1) begin
          grant_vld = 1'b1;
          grant_id  = rr_q;
        end else if (i_req_valid_0 || i_req_valid_1) begin
          grant_vld = 1'b1;
          grant_id  = i_req_valid_1;
        end
        if (grant_vld) begin
          o_req_ready_0 = ~grant_id;
          o_req_ready_1 = grant_id;
          rr_d          = ~grant_id;
          state_d       = ADD;
        end
      end
      ADD:     state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Operand capture from the granted requester.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (grant_vld) begin
      a_q  <= grant_id ? i_req_a_1 : i_req_a_0;
      b_q  <= grant_id ? i_req_b_1 : i_req_b_0;
      id_q <= grant_id;
    end
  end

  // Response registers: loaded in ADD, valid dropped on consumption only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else if (state_q == ADD) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_sum_q   <= add_sum;
      rsp_carry_q <= add_cout;
    end else if (state_q == RESP && i_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_carry = rsp_carry_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: accepts push expected results,
// a separate monitor pops and compares on every consumed response.
module tb_adder_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req_valid_0, i_req_valid_1;
  logic [7:0] i_req_a_0, i_req_b_0, i_req_a_1, i_req_b_1;
  logic       o_req_ready_0, o_req_ready_1;
  logic       o_rsp_valid, o_rsp_id, o_rsp_carry;
  logic [7:0] o_rsp_sum;
  logic       i_rsp_ready;
  logic       o_busy;

  adder_arbiter #(.WIDTH(8)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid_0 (i_req_valid_0),
    .i_req_a_0     (i_req_a_0),
    .i_req_b_0     (i_req_b_0),
    .o_req_ready_0 (o_req_ready_0),
    .i_req_valid_1 (i_req_valid_1),
    .i_req_a_1     (i_req_a_1),
    .i_req_b_1     (i_req_b_1),
    .o_req_ready_1 (o_req_ready_1),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_sum     (o_rsp_sum),
    .o_rsp_carry   (o_rsp_carry),
    .i_rsp_ready   (i_rsp_ready),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       id;
    logic [7:0] sum;
    logic       carry;
  } rsp_t;

  rsp_t sb_q[$];
  logic grant_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;

  // Hand-computed expected result for whatever each requester is presenting.
  logic [7:0] exp_sum0, exp_sum1;
  logic       exp_c0, exp_c1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endfunction

  // Accept observer: a ready seen mid-cycle means the pair is taken at the next edge.
  always @(negedge i_clk) begin
    if (!i_rst && (o_req_ready_0 || o_req_ready_1)) begin
      chk("ready_exclusive", 32'(o_req_ready_0 & o_req_ready_1), 32'(0));
      n_acc++;
      if (o_req_ready_0) sb_q.push_back(rsp_t'{1'b0, exp_sum0, exp_c0});
      else               sb_q.push_back(rsp_t'{1'b1, exp_sum1, exp_c1});
      if (grant_q.size() > 0) chk("grant_order", 32'(o_req_ready_1), 32'(grant_q.pop_front()));
    end
  end

  // Response monitor.
  always @(negedge i_clk) begin
    rsp_t e;
    if (!i_rst && o_rsp_valid && i_rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got id %0d sum %0h carry %0d, required no response",
                 o_rsp_id, o_rsp_sum, o_rsp_carry);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_id",    32'(o_rsp_id),    32'(e.id));
        chk("rsp_sum",   32'(o_rsp_sum),   32'(e.sum));
        chk("rsp_carry", 32'(o_rsp_carry), 32'(e.carry));
      end
    end
  end

  task automatic drive_edge;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] s, input logic c);
    logic got;
    got = 1'b0;
    drive_edge();
    if (id) begin
      i_req_valid_1 = 1'b1; i_req_a_1 = a; i_req_b_1 = b; exp_sum1 = s; exp_c1 = c;
    end else begin
      i_req_valid_0 = 1'b1; i_req_a_0 = a; i_req_b_0 = b; exp_sum0 = s; exp_c0 = c;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (id ? o_req_ready_1 : o_req_ready_0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'(0), 32'(1));
    drive_edge();
    if (id) i_req_valid_1 = 1'b0;
    else    i_req_valid_0 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (!o_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk(nm, 32'(o_busy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    i_rst = 1'b1;
    i_req_valid_0 = 1'b0; i_req_a_0 = '0; i_req_b_0 = '0;
    i_req_valid_1 = 1'b0; i_req_a_1 = '0; i_req_b_1 = '0;
    i_rsp_ready = 1'b1;
    exp_sum0 = '0; exp_sum1 = '0; exp_c0 = 1'b0; exp_c1 = 1'b0;

    #2;
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'(0));
    chk("rst_rsp_id",    32'(o_rsp_id),    32'(0));
    chk("rst_rsp_sum",   32'(o_rsp_sum),   32'(0));
    chk("rst_rsp_carry", 32'(o_rsp_carry), 32'(0));
    chk("rst_busy",      32'(o_busy),      32'(0));
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("idle_no_ready", 32'({o_req_ready_1, o_req_ready_0}), 32'(0));

    // Single request with exact latency.
    drive_edge();
    i_req_valid_0 = 1'b1; i_req_a_0 = 8'h12; i_req_b_0 = 8'h34;
    exp_sum0 = 8'h46; exp_c0 = 1'b0;
    @(negedge i_clk);
    chk("single_ready0", 32'(o_req_ready_0), 32'(1));
    drive_edge();
    i_req_valid_0 = 1'b0;
    @(negedge i_clk);
    chk("add_ready0_low", 32'(o_req_ready_0), 32'(0));
    chk("add_busy",       32'(o_busy),        32'(1));
    chk("add_no_valid",   32'(o_rsp_valid),   32'(0));
    drive_edge();
    @(negedge i_clk);
    chk("lat_rsp_valid",  32'(o_rsp_valid),   32'(1));
    drive_edge();
    @(negedge i_clk);
    chk("consumed_valid", 32'(o_rsp_valid),   32'(0));
    chk("consumed_busy",  32'(o_busy),        32'(0));
    chk("sum_held",       32'(o_rsp_sum),     32'(8'h46));

    // Overflow cases on requester 1.
    send(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
    wait_idle("ovf1_idle_timeout");
    send(1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    wait_idle("ovf2_idle_timeout");

    // Contention: both valid for 12 edges, expect 4 grants alternating.
    drive_edge();
    i_req_valid_0 = 1'b1; i_req_a_0 = 8'h10; i_req_b_0 = 8'h20; exp_sum0 = 8'h30; exp_c0 = 1'b0;
    i_req_valid_1 = 1'b1; i_req_a_1 = 8'h80; i_req_b_1 = 8'h90; exp_sum1 = 8'h10; exp_c1 = 1'b1;
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    acc0 = n_acc;
    repeat (12) @(posedge i_clk);
    #1;
    i_req_valid_0 = 1'b0; i_req_valid_1 = 1'b0;
    chk("contention_accepts", 32'(n_acc - acc0), 32'(4));
    chk("contention_grants_left", 32'(grant_q.size()), 32'(0));
    wait_idle("cont_idle_timeout");

    // Backpressure with a late request from requester 1 arriving during RESP.
    drive_edge();
    i_rsp_ready = 1'b0;
    send(1'b0, 8'h05, 8'h06, 8'h0B, 1'b0);
    drive_edge();
    i_req_valid_1 = 1'b1; i_req_a_1 = 8'h40; i_req_b_1 = 8'h41; exp_sum1 = 8'h81; exp_c1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("bp_valid",  32'(o_rsp_valid), 32'(1));
      chk("bp_sum",    32'(o_rsp_sum),   32'(8'h0B));
      chk("bp_id",     32'(o_rsp_id),    32'(0));
      chk("bp_ready",  32'({o_req_ready_1, o_req_ready_0}), 32'(0));
      chk("bp_busy",   32'(o_busy),      32'(1));
      drive_edge();
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("late_not_on_release", 32'(o_req_ready_1), 32'(0));
    drive_edge();
    @(negedge i_clk);
    chk("bp_release_idle", 32'(o_busy), 32'(0));
    chk("late_accept",     32'(o_req_ready_1), 32'(1));
    drive_edge();
    i_req_valid_1 = 1'b0; i_req_a_1 = 8'hAA; i_req_b_1 = 8'h55;
    wait_idle("late_idle_timeout");

    // Reset during ADD: state discarded, pointer back to requester 0.
    send(1'b0, 8'h22, 8'h11, 8'h33, 1'b0);
    #2 i_rst = 1'b1;
    sb_q.delete();
    #1;
    chk("mid_rst_valid", 32'(o_rsp_valid), 32'(0));
    chk("mid_rst_busy",  32'(o_busy),      32'(0));
    chk("mid_rst_sum",   32'(o_rsp_sum),   32'(0));
    chk("mid_rst_id",    32'(o_rsp_id),    32'(0));
    drive_edge();
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("mid_rst_no_rsp", 32'(o_rsp_valid), 32'(0));
    drive_edge();
    i_req_valid_0 = 1'b1; i_req_a_0 = 8'h01; i_req_b_0 = 8'h02; exp_sum0 = 8'h03; exp_c0 = 1'b0;
    i_req_valid_1 = 1'b1; i_req_a_1 = 8'h7F; i_req_b_1 = 8'h81; exp_sum1 = 8'h00; exp_c1 = 1'b1;
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    @(negedge i_clk);
    chk("post_rst_grant0", 32'(o_req_ready_0), 32'(1));
    repeat (6) @(posedge i_clk);
    #1;
    i_req_valid_0 = 1'b0; i_req_valid_1 = 1'b0;
    wait_idle("final_idle_timeout");

    chk("sb_drain",    32'(sb_q.size()),    32'(0));
    chk("grant_drain", 32'(grant_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
